fpmul_normalize: RTL and testbench



---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_round_rne.sv | 20 ++
 rtl/fpmul_normalize.sv | 168 ++++++++++++++++
 tb/tb_fpmul_normalize.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: FSM states, derived widths and IEEE-754
// special-value bit patterns parameterised by exponent/fraction width.
package fp_pkg;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

   function automatic int ext_man_bit(input int man_bit);
      return 2 * man_bit + 2;
   endfunction

   function automatic int exp_bias(input int exp_bit);
      return (1 << (exp_bit - 1)) - 1;
   endfunction

   // Patterns are returned right-aligned in 64 bits; callers slice N_BIT-1 bits.
   function automatic logic [63:0] inf_bits(input int exp_bit, input int man_bit);
      return ((64'd1 << exp_bit) - 64'd1) << man_bit;
   endfunction

   function automatic logic [63:0] qnan_bits(input int exp_bit, input int man_bit);
      return inf_bits(exp_bit, man_bit) | (64'd1 << (man_bit - 1));
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a mantissa given its guard and sticky bits.
module fp_round_rne #(
   parameter int MAN_BIT = 23
) (
   input  logic [MAN_BIT:0] m_in,
   input  logic             guard,
   input  logic             st,
   output logic [MAN_BIT:0] m_out,
   output logic             carry
);

   logic inc;

   always_comb begin
      // A tie (guard set, nothing below) rounds only when it makes the LSB even.
      inc            = guard & (st | m_in[0]);
      {carry, m_out} = {1'b0, m_in} + {{(MAN_BIT + 1){1'b0}}, inc};
   end

endmodule

// File: rtl/fpmul_normalize.sv
// Normalize-and-round stage after the FP multiplier: one shift per cycle,
// RNE rounding, single-entry output held under a valid/ready handshake.
module fpmul_normalize
   import fp_pkg::*;
#(
   parameter int LOG_BIT = 5,
   parameter int EXP_BIT = 8,
   parameter int N_BIT   = 1 << LOG_BIT,
   parameter int MAN_BIT = N_BIT - EXP_BIT - 1,
   localparam int EXT_MAN_BIT = ext_man_bit(MAN_BIT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_BIT+1:0]     in_exp,
   input  logic [EXT_MAN_BIT-1:0] in_prod,
   input  logic                   in_nan,
   input  logic                   in_inf,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_BIT-1:0]       out,
   output logic                   out_ovf,
   output logic                   out_unf,
   output logic                   out_inexact
);

   localparam int EXT = EXT_MAN_BIT;
   localparam logic [63:0] INF_W  = inf_bits(EXP_BIT, MAN_BIT);
   localparam logic [63:0] QNAN_W = qnan_bits(EXP_BIT, MAN_BIT);
   localparam logic signed [EXP_BIT+1:0] E_ZERO = (EXP_BIT + 2)'(0);
   localparam logic signed [EXP_BIT+1:0] E_ONE  = (EXP_BIT + 2)'(1);
   localparam logic signed [EXP_BIT+1:0] E_MAX  = (EXP_BIT + 2)'((1 << EXP_BIT) - 1);

   state_e                    state_q, state_d;
   logic [EXT-1:0]            p_q, p_d;
   logic signed [EXP_BIT+1:0] e_q, e_d;
   logic                      s_q, s_d;
   logic                      sticky_q, sticky_d;
   logic [N_BIT-1:0]          out_q, out_d;
   logic                      ovf_q, ovf_d;
   logic                      unf_q, unf_d;
   logic                      inx_q, inx_d;

   logic [MAN_BIT:0]          m_pre, m_rnd, m_fin;
   logic                      guard, st, carry;
   logic signed [EXP_BIT+1:0] e_rnd;
   logic [EXT-1:0]            p_shr;

   assign m_pre = p_q[EXT-2 -: MAN_BIT + 1];
   assign guard = p_q[MAN_BIT-1];
   assign st    = sticky_q | (|p_q[MAN_BIT-2:0]);

   fp_round_rne #(.MAN_BIT(MAN_BIT)) u_round (
      .m_in  (m_pre),
      .guard (guard),
      .st    (st),
      .m_out (m_rnd),
      .carry (carry)
   );

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      e_d      = e_q;
      s_d      = s_q;
      sticky_d = sticky_q;
      out_d    = out_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      p_shr    = p_q >> 1;
      // Mantissa overflow from rounding renormalises to 1.000... with E+1.
      m_fin    = carry ? {1'b1, {MAN_BIT{1'b0}}} : m_rnd;
      e_rnd    = e_q + (carry ? E_ONE : E_ZERO);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               p_d      = in_prod;
               e_d      = $signed(in_exp);
               s_d      = in_sign;
               sticky_d = 1'b0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
               if (in_nan) begin
                  out_d   = {in_sign, QNAN_W[N_BIT-2:0]};
                  state_d = DONE;
               end else if (in_inf) begin
                  out_d   = {in_sign, INF_W[N_BIT-2:0]};
                  state_d = DONE;
               end else if (in_prod == '0) begin
                  out_d   = {in_sign, {(N_BIT - 1){1'b0}}};
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (p_q[EXT-1] || (e_q < E_ONE)) begin
               // Once everything has been shifted out, pin E so the loop ends.
               p_d      = p_shr;
               sticky_d = sticky_q | p_q[0];
               e_d      = (p_shr == '0) ? E_ONE : e_q + E_ONE;
            end else if (!p_q[EXT-2] && (e_q > E_ONE)) begin
               p_d = p_q << 1;
               e_d = e_q - E_ONE;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (e_rnd >= E_MAX) begin
               out_d = {s_q, INF_W[N_BIT-2:0]};
               ovf_d = 1'b1;
               unf_d = 1'b0;
               inx_d = 1'b1;
            end else begin
               out_d = {s_q, (m_fin[MAN_BIT] ? e_rnd[EXP_BIT-1:0] : {EXP_BIT{1'b0}}),
                        m_fin[MAN_BIT-1:0]};
               ovf_d = 1'b0;
               inx_d = guard | st;
               unf_d = (guard | st) & ~p_q[EXT-2];
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         inx_q   <= inx_d;
      end
   end

   // Working registers are always reloaded on acceptance, so they need no reset.
   always_ff @(posedge clk) begin
      p_q      <= p_d;
      e_q      <= e_d;
      s_q      <= s_d;
      sticky_q <= sticky_d;
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out         = out_q;
   assign out_ovf     = ovf_q;
   assign out_unf     = unf_q;
   assign out_inexact = inx_q;

endmodule

// File: tb/tb_fpmul_normalize.sv
// Directed bench for fpmul_normalize with hand-computed single-precision results.
module tb_fpmul_normalize;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [9:0]  in_exp = '0;
   logic [47:0] in_prod = '0;
   logic        in_nan = 1'b0;
   logic        in_inf = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out;
   logic        out_ovf, out_unf, out_inexact;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        sgn;
      logic        nan;
      logic        inf;
      int          ex;
      logic [47:0] prod;
      logic [31:0] res;
      logic [2:0]  fl;   // {ovf, unf, inexact}
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   fpmul_normalize dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
      .in_nan(in_nan), .in_inf(in_inf),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
   );

   // Presents one transaction and counts cycles from acceptance to out_valid (-1 on timeout).
   task automatic run_txn(input vec_t v, output int lat);
      logic [31:0] exv;
      exv = v.ex;
      @(negedge clk);
      in_sign  = v.sgn;
      in_nan   = v.nan;
      in_inf   = v.inf;
      in_exp   = exv[9:0];
      in_prod  = v.prod;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_nan   = 1'b0;
      in_inf   = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic pop();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'h0 ||
          {out_ovf, out_unf, out_inexact} !== 3'b000) begin
         failures++;
         $display("FAIL reset: out_valid=%b in_ready=%b out=%h flags=%b (want 0 1 00000000 000)",
                  out_valid, in_ready, out, {out_ovf, out_unf, out_inexact});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors(input string name, input vec_t vs[$]);
      int lat;
      foreach (vs[i]) begin
         run_txn(vs[i], lat);
         checks++;
         if (lat !== vs[i].lat) begin
            failures++;
            $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, vs[i].lat);
         end
         checks++;
         if (out !== vs[i].res) begin
            failures++;
            $display("FAIL %s[%0d] out: got %h want %h", name, i, out, vs[i].res);
         end
         checks++;
         if ({out_ovf, out_unf, out_inexact} !== vs[i].fl) begin
            failures++;
            $display("FAIL %s[%0d] flags ovf/unf/inx: got %b want %b", name, i,
                     {out_ovf, out_unf, out_inexact}, vs[i].fl);
         end
         pop();
      end
   endtask

   task automatic test_normal();
      vec_t vs[$];
      vs.push_back('{1'b0, 1'b0, 1'b0, 128, 48'h6000_0000_0000, 32'h4040_0000, 3'b000, 3});
      vs.push_back('{1'b0, 1'b0, 1'b0, 128, 48'h8000_0000_0000, 32'h4080_0000, 3'b000, 4});
      vs.push_back('{1'b1, 1'b0, 1'b0, 127, 48'h2000_0000_0000, 32'hBF00_0000, 3'b000, 4});
      vs.push_back('{1'b0, 1'b0, 1'b0, 127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001, 3});
      test_vectors("normal", vs);
   endtask

   task automatic test_overflow();
      vec_t vs[$];
      vs.push_back('{1'b0, 1'b0, 1'b0, 300, 48'h4000_0000_0000, 32'h7F80_0000, 3'b101, 3});
      vs.push_back('{1'b1, 1'b0, 1'b0, 254, 48'h7FFF_FFC0_0000, 32'hFF80_0000, 3'b101, 3});
      test_vectors("overflow", vs);
   endtask

   task automatic test_rne_ties();
      vec_t vs[$];
      vs.push_back('{1'b0, 1'b0, 1'b0, 127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001, 3});
      vs.push_back('{1'b0, 1'b0, 1'b0, 127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001, 3});
      vs.push_back('{1'b0, 1'b0, 1'b0, 127, 48'h4000_0040_0001, 32'h3F80_0001, 3'b001, 3});
      test_vectors("rne", vs);
   endtask

   task automatic test_denormal();
      vec_t vs[$];
      vs.push_back('{1'b0, 1'b0, 1'b0, -1,  48'h4000_0000_0000, 32'h0020_0000, 3'b000, 5});
      vs.push_back('{1'b0, 1'b0, 1'b0, -1,  48'h4000_0000_0001, 32'h0020_0000, 3'b011, 5});
      vs.push_back('{1'b1, 1'b0, 1'b0, -60, 48'h4000_0000_0000, 32'h8000_0000, 3'b011, 50});
      test_vectors("denormal", vs);
   endtask

   task automatic test_special();
      vec_t vs[$];
      vs.push_back('{1'b0, 1'b0, 1'b1, 5,   48'h4000_0000_0000, 32'h7F80_0000, 3'b000, 1});
      vs.push_back('{1'b0, 1'b1, 1'b1, 5,   48'h4000_0000_0000, 32'h7FC0_0000, 3'b000, 1});
      vs.push_back('{1'b1, 1'b0, 1'b0, 300, 48'h0,              32'h8000_0000, 3'b000, 1});
      test_vectors("special", vs);
   endtask

   task automatic test_backpressure();
      vec_t v;
      int lat;
      v = '{1'b1, 1'b1, 1'b0, 0, 48'h0, 32'hFFC0_0000, 3'b000, 1};
      run_txn(v, lat);
      checks++;
      if (lat !== 1 || out !== 32'hFFC0_0000) begin
         failures++;
         $display("FAIL bp_nan: lat=%0d out=%h want lat=1 out=ffc00000", lat, out);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out !== 32'hFFC0_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d]: out=%h out_valid=%b in_ready=%b want ffc00000 1 0",
                     i, out, out_valid, in_ready);
         end
      end
      pop();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_norm();
      vec_t v;
      int lat;
      @(negedge clk);
      in_sign  = 1'b0;
      in_exp   = 10'd50;
      in_prod  = 48'h0000_4000_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_norm_busy: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_norm_reset: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      v = '{1'b0, 1'b0, 1'b0, 128, 48'h6000_0000_0000, 32'h4040_0000, 3'b000, 3};
      run_txn(v, lat);
      checks++;
      if (lat !== 3 || out !== 32'h4040_0000) begin
         failures++;
         $display("FAIL after_reset: lat=%0d out=%h want 3 40400000", lat, out);
      end
      pop();
   endtask

   task automatic test_back_to_back();
      vec_t v;
      int lat;
      v = '{1'b0, 1'b0, 1'b1, 0, 48'h0, 32'h7F80_0000, 3'b000, 1};
      run_txn(v, lat);
      // Offer the next input in the same cycle as the output handshake.
      @(negedge clk);
      in_exp    = 10'd128;
      in_prod   = 48'h6000_0000_0000;
      in_sign   = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL no_turnaround: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: in_ready=%b want 0", in_ready);
      end
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 3 || out !== 32'hC040_0000) begin
         failures++;
         $display("FAIL b2b_result: lat=%0d out=%h want 3 c0400000", lat, out);
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_overflow();
      test_rne_ties();
      test_denormal();
      test_special();
      test_backpressure();
      test_reset_mid_norm();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
